// File: rtl/uart_rx_fsmd_pkg.sv
// Shared UART definitions: FSM state encoding, line bit-select codes and the
// default oversample ratio, common to the TX and RX ends of the link.
package uart_rx_fsmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Line-level bit selects; the transmitter uses these to drive its output mux.
    typedef enum logic [1:0] {
        SELECT_0      = 2'd0,
        SELECT_1      = 2'd1,
        SELECT_DATA   = 2'd2,
        SELECT_PARITY = 2'd3
    } uart_bit_sel_e;

    localparam int DEFAULT_NO_OF_CLKS = 16;

endpackage

// File: rtl/uart_rx_fsmd_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// (high) level so a reset never looks like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_fsmd.sv
// UART receiver: oversampled start-bit validation, LSB-first data shift,
// optional parity check and stop-bit check, with a one-clock valid pulse.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | line idle, waiting for a low sample
// ST_START  | counting to mid start bit; high there rejects it as a glitch
// ST_DATA   | sampling data bits at mid-bit, shifting into the MSB
// ST_PARITY | sampling parity bit and computing the parity error
// ST_STOP   | sampling stop bit; result is presented on the following clock
module uart_rx_fsmd
    import uart_rx_fsmd_pkg::*;
#(
    parameter logic parity_on           = 1'b1,
    parameter logic parity_odd          = 1'b0,
    parameter int   data_size           = 8,
    parameter int   sampling_cntr_width = 4,
    parameter int   no_of_clks          = DEFAULT_NO_OF_CLKS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 rx_in,
    output logic [data_size-1:0] rx_data,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam logic [sampling_cntr_width-1:0] SCNT_HALF = sampling_cntr_width'(no_of_clks / 2 - 1);
    localparam logic [sampling_cntr_width-1:0] SCNT_LAST = sampling_cntr_width'(no_of_clks - 1);
    localparam logic [2:0]                     BCNT_LAST = 3'(data_size - 1);

    uart_state_e                  state;
    uart_state_e                  state_nxt;
    logic                         rx_s;
    logic [sampling_cntr_width-1:0] scnt;
    logic [2:0]                   bcnt;
    logic [data_size-1:0]         shift_q;
    logic                         p_err_q;
    logic                         stop_q;
    logic                         done_q;
    logic                         at_half;
    logic                         at_last;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (sample_tick) begin
            case (state)
                ST_IDLE:   if (!rx_s) state_nxt = ST_START;
                ST_START:  if (at_half) state_nxt = rx_s ? ST_IDLE : ST_DATA;
                ST_DATA:   if (at_last && bcnt == BCNT_LAST)
                               state_nxt = parity_on ? ST_PARITY : ST_STOP;
                ST_PARITY: if (at_last) state_nxt = ST_STOP;
                ST_STOP:   if (at_last) state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (state != ST_IDLE);
        at_half = (scnt == SCNT_HALF);
        at_last = (scnt == SCNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            scnt    <= '0;
            bcnt    <= '0;
            shift_q <= '0;
            p_err_q <= 1'b0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (sample_tick) begin
                case (state)
                    ST_IDLE: scnt <= '0;
                    ST_START: begin
                        scnt <= at_half ? '0 : scnt + 1'b1;
                        bcnt <= '0;
                    end
                    ST_DATA: begin
                        if (at_last) begin
                            scnt    <= '0;
                            bcnt    <= bcnt + 3'd1;
                            shift_q <= {rx_s, shift_q[data_size-1:1]};
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        if (at_last) begin
                            scnt    <= '0;
                            p_err_q <= (^shift_q) ^ rx_s ^ parity_odd;
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (at_last) begin
                            scnt   <= '0;
                            stop_q <= rx_s;
                            done_q <= 1'b1;
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                    default: scnt <= '0;
                endcase
            end
        end
    end

    // Results land one clock after the stop sample so a new start can already be in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_data    <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= done_q;
            if (done_q) begin
                rx_data    <= shift_q;
                frame_err  <= ~stop_q;
                parity_err <= p_err_q;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fsmd.sv
// Directed bench for uart_rx_fsmd: 8 data bits, even parity, 16 ticks per bit.
module tb_uart_rx_fsmd;

    logic       clk;
    logic       rst;
    logic       sample_tick;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int tick_div = 1;
    int tick_cnt = 0;
    int n_valid  = 0;
    logic [7:0] cap_q[$];

    uart_rx_fsmd #(
        .parity_on           (1'b1),
        .parity_odd          (1'b0),
        .data_size           (8),
        .sampling_cntr_width (4),
        .no_of_clks          (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .rx_in       (rx_in),
        .rx_data     (rx_data),
        .data_valid  (data_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        sample_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_cnt >= tick_div - 1) begin
                tick_cnt    = 0;
                sample_tick = 1'b1;
            end else begin
                tick_cnt    = tick_cnt + 1;
                sample_tick = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (data_valid) begin
                n_valid = n_valid + 1;
                cap_q.push_back(rx_data);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (sample_tick) k = k + 1;
        end
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        wait_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stp);
        rx_in = 1'b1;
    endtask

    task automatic check_frame(input string tag, input int v0, input logic [7:0] d,
                               input logic pe, input logic fe);
        check_eq({tag, "_valid_cnt"}, n_valid - v0, 1);
        check_eq({tag, "_data"}, rx_data, d);
        check_eq({tag, "_perr"}, parity_err, pe);
        check_eq({tag, "_ferr"}, frame_err, fe);
        check_eq({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int v0;
        rst   = 1'b0;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_data", rx_data, 8'h00);
        check_eq("rst_valid", data_valid, 1'b0);
        check_eq("rst_perr", parity_err, 1'b0);
        check_eq("rst_ferr", frame_err, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        rst = 1'b1;
        wait_ticks(20);

        // good frame, even parity bit 0
        v0 = n_valid;
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_ticks(4);
        check_frame("a5", v0, 8'hA5, 1'b0, 1'b0);

        // wrong parity bit
        v0 = n_valid;
        send_frame(8'h3C, 1'b1, 1'b1);
        wait_ticks(4);
        check_frame("3c", v0, 8'h3C, 1'b1, 1'b0);

        // stop bit low, then idle line must not produce another word
        v0 = n_valid;
        send_frame(8'h81, 1'b0, 1'b0);
        wait_ticks(4);
        check_eq("81_valid_cnt", n_valid - v0, 1);
        check_eq("81_data", rx_data, 8'h81);
        check_eq("81_perr", parity_err, 1'b0);
        check_eq("81_ferr", frame_err, 1'b1);
        wait_ticks(40);
        check_eq("81_no_extra_valid", n_valid - v0, 1);
        check_eq("81_idle_busy", busy, 1'b0);

        // short low pulse: start entered, then rejected at mid start bit
        v0 = n_valid;
        rx_in = 1'b0;
        wait_ticks(5);
        check_eq("glitch_busy_hi", busy, 1'b1);
        rx_in = 1'b1;
        wait_ticks(20);
        check_eq("glitch_busy_lo", busy, 1'b0);
        check_eq("glitch_no_valid", n_valid - v0, 0);
        check_eq("glitch_data_hold", rx_data, 8'h81);
        check_eq("glitch_ferr_hold", frame_err, 1'b1);

        // back-to-back frames with a slower tick
        tick_div = 3;
        wait_ticks(4);
        v0 = n_valid;
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        wait_ticks(4);
        check_eq("b2b_valid_cnt", n_valid - v0, 2);
        if (cap_q.size() >= 2) begin
            check_eq("b2b_first", cap_q[cap_q.size() - 2], 8'h00);
            check_eq("b2b_second", cap_q[cap_q.size() - 1], 8'hFF);
        end else begin
            check_eq("b2b_capture_size", cap_q.size(), 2);
        end
        check_eq("b2b_perr", parity_err, 1'b0);
        check_eq("b2b_ferr", frame_err, 1'b0);

        // reset in the middle of data bit 4
        tick_div = 1;
        wait_ticks(4);
        v0 = n_valid;
        rx_in = 1'b0;
        wait_ticks(16);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rx_in = 1'b1;
        wait_ticks(4);
        check_eq("pre_rst_busy", busy, 1'b1);
        rst   = 1'b0;
        rx_in = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_eq("mid_rst_data", rx_data, 8'h00);
        check_eq("mid_rst_valid", data_valid, 1'b0);
        check_eq("mid_rst_perr", parity_err, 1'b0);
        check_eq("mid_rst_ferr", frame_err, 1'b0);
        check_eq("mid_rst_busy", busy, 1'b0);
        wait_ticks(40);
        check_eq("mid_rst_no_valid", n_valid - v0, 0);

        v0 = n_valid;
        send_frame(8'h5A, 1'b0, 1'b1);
        wait_ticks(4);
        check_frame("5a", v0, 8'h5A, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
